// File: rtl/riscv_test_pkg.sv
// rtl/riscv_test_pkg.sv - status encodings, dump phases and default convention register indices
package riscv_test_pkg;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_PASS    = 3'd2,
        ST_FAIL    = 3'd3,
        ST_TIMEOUT = 3'd4
    } status_e;

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_FETCH,
        DS_VALID,
        DS_DONE
    } dump_phase_e;

    localparam int DEF_TNUM_REG = 3;
    localparam int DEF_DONE_REG = 26;
    localparam int DEF_PASS_REG = 27;

    function automatic logic is_verdict(input status_e s);
        return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
    endfunction

endpackage

// File: rtl/reg_dump_seq.sv
// rtl/reg_dump_seq.sv - walks every architectural register out over a valid/ready stream
module reg_dump_seq import riscv_test_pkg::*; #(
    parameter int  XLEN = 32,
    parameter int  NREG = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    output logic [AW-1:0]   o_rf_raddr,
    input  logic [XLEN-1:0] i_rf_rdata,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [AW-1:0]   o_idx,
    output logic [XLEN-1:0] o_data
);

    dump_phase_e     r_phase;
    dump_phase_e     w_phase_nxt;
    logic [AW-1:0]   r_raddr;
    logic [AW-1:0]   r_idx;
    logic [XLEN-1:0] r_data;
    logic            w_accept;
    logic            w_last;

    assign w_accept = (r_phase == DS_VALID) && i_ready;
    assign w_last   = (r_idx == AW'(NREG - 1));

    // One fetch cycle per beat: the read address settles, then data is captured.
    always_comb begin
        w_phase_nxt = r_phase;
        case (r_phase)
            DS_IDLE:  if (i_start) w_phase_nxt = DS_FETCH;
            DS_FETCH: w_phase_nxt = DS_VALID;
            DS_VALID: if (w_accept) w_phase_nxt = w_last ? DS_DONE : DS_FETCH;
            default:  w_phase_nxt = r_phase;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_phase <= DS_IDLE;
            r_raddr <= '0;
            r_idx   <= '0;
            r_data  <= '0;
        end else begin
            r_phase <= w_phase_nxt;
            if ((r_phase == DS_IDLE) && i_start) begin
                r_raddr <= '0;
            end
            if (r_phase == DS_FETCH) begin
                r_data <= i_rf_rdata;
                r_idx  <= r_raddr;
            end
            if (w_accept && !w_last) begin
                r_raddr <= r_raddr + AW'(1);
            end
        end
    end

    assign o_rf_raddr = r_raddr;
    assign o_valid    = (r_phase == DS_VALID);
    assign o_idx      = r_idx;
    assign o_data     = r_data;

endmodule

// File: rtl/riscv_test_monitor.sv
// rtl/riscv_test_monitor.sv - snoops write-back for riscv-tests flags and issues pass/fail/timeout verdicts
module riscv_test_monitor import riscv_test_pkg::*; #(
    parameter int  XLEN           = 32,
    parameter int  NREG           = 32,
    parameter int  TNUM_REG       = DEF_TNUM_REG,
    parameter int  DONE_REG       = DEF_DONE_REG,
    parameter int  PASS_REG       = DEF_PASS_REG,
    parameter int  SETTLE_CYCLES  = 10,
    parameter int  TIMEOUT_CYCLES = 100000,
    parameter int  CNT_W          = 32,
    localparam int AW             = $clog2(NREG)
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             wb_we,
    input  logic [AW-1:0]    wb_waddr,
    input  logic [XLEN-1:0]  wb_wdata,
    output logic [AW-1:0]    rf_raddr,
    input  logic [XLEN-1:0]  rf_rdata,
    output logic [2:0]       status,
    output logic             verdict_valid,
    output logic [XLEN-1:0]  fail_testnum,
    output logic [CNT_W-1:0] cycle_count,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [AW-1:0]    dump_idx,
    output logic [XLEN-1:0]  dump_data
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    status_e          r_state;
    status_e          w_state_nxt;
    logic [XLEN-1:0]  r_tnum;
    logic [XLEN-1:0]  r_pass;
    logic [CNT_W-1:0] r_cycle;
    logic [SW-1:0]    r_settle;
    logic             w_live;
    logic             w_wr_ok;
    logic             w_done_hit;
    logic             w_timeout;
    logic             w_dump_start;

    // Register 0 is hardwired in the core, so writes aimed at it never count.
    assign w_live       = (r_state == ST_RUN) || (r_state == ST_SETTLE);
    assign w_wr_ok      = wb_we && (wb_waddr != '0) && w_live;
    assign w_done_hit   = w_wr_ok && (wb_waddr == AW'(DONE_REG)) && (wb_wdata == XLEN'(1));
    assign w_timeout    = (TIMEOUT_CYCLES != 0) && (r_cycle >= CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_dump_start = w_live && ((w_state_nxt == ST_FAIL) || (w_state_nxt == ST_TIMEOUT));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_done_hit) begin
                    w_state_nxt = ST_SETTLE;
                end else if (w_timeout) begin
                    w_state_nxt = ST_TIMEOUT;
                end
            end
            ST_SETTLE: begin
                if (r_settle == SW'(1)) begin
                    w_state_nxt = (r_pass == XLEN'(1)) ? ST_PASS : ST_FAIL;
                end
            end
            default: w_state_nxt = r_state;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state  <= ST_RUN;
            r_tnum   <= '0;
            r_pass   <= '0;
            r_cycle  <= '0;
            r_settle <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_wr_ok && (wb_waddr == AW'(TNUM_REG))) begin
                r_tnum <= wb_wdata;
            end
            if (w_wr_ok && (wb_waddr == AW'(PASS_REG))) begin
                r_pass <= wb_wdata;
            end
            // The verdict edge itself is not counted, so the count freezes there.
            if (w_live && ((w_state_nxt == ST_RUN) || (w_state_nxt == ST_SETTLE)) && (r_cycle != '1)) begin
                r_cycle <= r_cycle + CNT_W'(1);
            end
            if ((r_state == ST_RUN) && w_done_hit) begin
                r_settle <= SW'(SETTLE_CYCLES);
            end else if (r_state == ST_SETTLE) begin
                r_settle <= r_settle - SW'(1);
            end
        end
    end

    reg_dump_seq #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_dump (
        .i_clk      (sys_clk),
        .i_rst      (sys_rst),
        .i_start    (w_dump_start),
        .o_rf_raddr (rf_raddr),
        .i_rf_rdata (rf_rdata),
        .o_valid    (dump_valid),
        .i_ready    (dump_ready),
        .o_idx      (dump_idx),
        .o_data     (dump_data)
    );

    assign status        = r_state;
    assign verdict_valid = is_verdict(r_state);
    assign fail_testnum  = r_tnum;
    assign cycle_count   = r_cycle;

endmodule

// File: doc/riscv_test_monitor.md
# riscv_test_monitor

Synthesizable, parametrised test-completion monitor for the open_risc_v core. It snoops the register-file write-back port and tracks the riscv-tests convention registers: test number, done flag and pass flag. After a programmable settle window it issues a pass/fail/timeout verdict. On fail or timeout it streams every architectural register out over a valid/ready port, so one block serves both simulation and FPGA bring-up.

## Interface
- XLEN, 32, data width
- NREG, 32, architectural register count; AW = clog2(NREG)
- TNUM_REG, 3, index of the test-number register
- DONE_REG, 26, index of the done-flag register
- PASS_REG, 27, index of the pass-flag register
- SETTLE_CYCLES, 10, cycles between the done write and the verdict (≥1)
- TIMEOUT_CYCLES, 100000, RUN-cycle limit; 0 disables the watchdog
- CNT_W, 32, cycle-counter width
- sys_clk in 1 — single clock
- sys_rst in 1 — asynchronous, active-high reset
- wb_we in 1 — register-file write enable
- wb_waddr in AW — write index
- wb_wdata in XLEN — write data
- rf_raddr out AW — dump read address (registered)
- rf_rdata in XLEN — combinational register-file read data for rf_raddr
- status out 3 — RUN/SETTLE/PASS/FAIL/TIMEOUT
- verdict_valid out 1 — high in PASS/FAIL/TIMEOUT
- fail_testnum out XLEN — shadow TNUM_REG value at verdict
- cycle_count out CNT_W — cycles spent in RUN+SETTLE
- dump_valid out 1, dump_ready in 1, dump_idx out AW, dump_data out XLEN — register dump stream

## Operation
- Reset values:
  - state RUN; all shadows 0; cycle_count 0; rf_raddr 0
  - dump_valid 0, dump_idx 0, dump_data 0; verdict_valid 0
- Shadows:
  - A write with wb_we=1 and waddr ∈ {TNUM, DONE, PASS} updates the matching shadow.
  - Writes to index 0 are ignored.
  - Shadows freeze once a verdict is issued.
- RUN:
  - cycle_count increments each cycle and saturates at all-ones.
  - A write of exactly 1 to DONE_REG moves to SETTLE; any other done value only updates the shadow.
  - If TIMEOUT_CYCLES≠0 and cycle_count reaches TIMEOUT_CYCLES-1 with no done write, the block moves to TIMEOUT.
  - A done=1 write in the same cycle as the timeout wins.
- SETTLE:
  - Shadow updates continue and cycle_count keeps counting; the settle counter is loaded with SETTLE_CYCLES.
  - A further DONE write is ignored.
  - When the counter expires: pass shadow == 1 goes to PASS, anything else goes to FAIL.
- PASS is terminal and produces no dump.
- FAIL and TIMEOUT start the dump immediately and remain the reported status.
- fail_testnum is valid in both.
- Dump sequence:
  - For idx = 0..NREG-1: rf_raddr←idx, then next cycle dump_data←rf_rdata, dump_idx←idx, dump_valid←1.
  - dump_data is held stable until dump_valid&dump_ready.
  - After the beat with idx NREG-1 is accepted, dump_valid stays 0 permanently.
- Reset mid-operation, including mid-dump, aborts to the reset values; a partial dump is not resumed.

## Timing
- Done write sampled at edge E: status=SETTLE after E.
- PASS/FAIL/TIMEOUT after edge E+SETTLE_CYCLES.
- verdict_valid rises with status.
- Dump timing:
  - Verdict at edge V (FAIL/TIMEOUT): rf_raddr=0 after V, first dump_valid after V+1.
  - Beat accepted at edge A: dump_valid=0 after A, next beat valid after A+1.
  - Peak rate is one beat per 2 cycles; full dump takes ≥2·NREG cycles.
- cycle_count freezes at the edge that issues the verdict.

## Structure
- Package riscv_test_pkg: status encodings (RUN=0, SETTLE=1, PASS=2, FAIL=3, TIMEOUT=4) and the default register indices.
- Sub-module reg_dump_seq holds the index counter, rf_raddr/dump_data registers and the valid/ready handshake.
- The top holds the verdict FSM, shadows and counters.

## Test plan
- TNUM←5, PASS←1, DONE←1 at cycle 100 → SETTLE at 101, PASS at 111 (SETTLE=10), no dump_valid ever, cycle_count=110.
- TNUM←7, PASS←0, DONE←1 → FAIL, fail_testnum=7, 32 beats idx 0..31 whose dump_data matches a preloaded RF, dump_ready=1 gives one beat every 2 cycles.
- PASS←1 written 3 cycles after DONE←1 (inside settle) → PASS; a DONE←2 write alone → stays RUN.
- TIMEOUT_CYCLES=50, no done write → status TIMEOUT at cycle 50, dump with dump_ready toggled randomly, each dump_data held until accepted.
- Reset asserted mid-dump at beat 12 → immediate RUN, dump_valid=0, all shadows 0; next run dumps from idx 0.
- Write to waddr 0 with data 1 while DONE_REG=0 parameter → ignored, stays RUN.
